// File: rtl/mul_sequencer.sv
// Shift-add multiplier sequencer: one multiplier bit per clock, then a sign-fix
// cycle that publishes the full product and a Q1.(WIDTH-1) fractional result.
module mul_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic               Clock,
  input  logic               nReset,
  input  logic               Start,
  input  logic               Abort,
  input  logic               Signed,
  input  logic [WIDTH-1:0]   OpA,
  input  logic [WIDTH-1:0]   OpB,
  output logic [2*WIDTH-1:0] Product,
  output logic [WIDTH-1:0]   Frac,
  output logic               Busy,
  output logic               Done,
  output logic               Stall
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] acc;
  logic               neg;
  logic               sgn;
  logic               ovf;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH-1:0]   frac_next;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? -v : v;
  endfunction

  // Right-shift accumulator: the carry out of the upper half shifts back in,
  // so (2^W-1)^2 is represented without loss in 2*WIDTH bits.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sum       = '0;
    acc_step  = acc;
    prod_next = acc;
    frac_next = '0;
    sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mag_b[0] ? {1'b0, mag_a} : '0);
    acc_step  = {sum, acc[WIDTH-1:1]};
    prod_next = neg ? -acc : acc;
    if (!sgn)
      frac_next = prod_next[2*WIDTH-1:WIDTH];
    else if (ovf)
      frac_next = {1'b0, {(WIDTH-1){1'b1}}};
    else
      frac_next = prod_next[2*WIDTH-2 -: WIDTH];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      // NOTE: datapath registers are reset too; they are few and a clean
      // post-reset state keeps the outputs and a reset-abort deterministic.
      state   <= IDLE;
      count   <= '0;
      mag_a   <= '0;
      mag_b   <= '0;
      acc     <= '0;
      neg     <= 1'b0;
      sgn     <= 1'b0;
      ovf     <= 1'b0;
      Product <= '0;
      Frac    <= '0;
      Done    <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start && !Abort) begin
            state <= RUN;
            count <= CW'(WIDTH - 1);
            mag_a <= magnitude(OpA, Signed);
            mag_b <= magnitude(OpB, Signed);
            neg   <= Signed & (OpA[WIDTH-1] ^ OpB[WIDTH-1]);
            sgn   <= Signed;
            ovf   <= Signed && (OpA == MIN_NEG) && (OpB == MIN_NEG);
            acc   <= '0;
          end
        end
        RUN: begin
          if (Abort) begin
            state <= IDLE;
          end else begin
            acc   <= acc_step;
            mag_b <= mag_b >> 1;
            if (count == '0) state <= FIX;
            else             count <= count - 1'b1;
          end
        end
        FIX: begin
          state <= IDLE;
          if (!Abort) begin
            Product <= prod_next;
            Frac    <= frac_next;
            Done    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Busy  = (state != IDLE);
  assign Stall = Busy | (Start & ~Abort);

endmodule
